// File: rtl/traffic_lane_model.sv
// Closed-loop vehicle/sensor model for a four-approach traffic controller.
// Tracks per-lane queues, departs cars under Green, and flags illegal lamp states.
module traffic_lane_model #(
  parameter int QW        = 4,
  parameter int DEP_CYC   = 2,
  parameter int START_DLY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_E,
  input  logic          arr_NL,
  input  logic          arr_EL,
  input  logic          arr_W,
  input  logic [6:0]    ETL,
  input  logic [6:0]    NLTL,
  input  logic [6:0]    ELTL,
  input  logic [6:0]    WTL,
  output logic          E,
  output logic          NL,
  output logic          EL,
  output logic          W,
  output logic [QW-1:0] q_E,
  output logic [QW-1:0] q_NL,
  output logic [QW-1:0] q_EL,
  output logic [QW-1:0] q_W,
  output logic [3:0]    moving,
  output logic [3:0]    overflow,
  output logic [3:0]    code_err,
  output logic          conflict
);

  localparam logic [6:0]    RED          = 7'b0101111;
  localparam logic [6:0]    GREEN        = 7'b0010000;
  localparam logic [6:0]    YELLOW       = 7'b0010001;
  localparam logic [QW-1:0] MAXQ         = {QW{1'b1}};
  localparam logic [3:0]    DEP_RELOAD   = 4'(DEP_CYC - 1);
  localparam logic [3:0]    START_RELOAD = 4'(START_DLY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, MOVE} lane_st_t;

  lane_st_t      state_q [4];
  lane_st_t      state_d [4];
  logic [3:0]    cnt_q   [4];
  logic [3:0]    cnt_d   [4];
  logic [QW-1:0] qcnt_q  [4];
  logic [QW-1:0] qcnt_d  [4];
  logic [6:0]    code    [4];

  logic [3:0] arr, legal, green, lit, dep;
  logic [3:0] sensor_q, sensor_d;
  logic [3:0] ovf_q, ovf_d;
  logic [3:0] cerr_q, cerr_d;
  logic       conflict_q, conflict_d;

  assign arr  = {arr_W, arr_EL, arr_NL, arr_E};
  assign code[0] = ETL;
  assign code[1] = NLTL;
  assign code[2] = ELTL;
  assign code[3] = WTL;

  // Illegal codes decode as Red: not green, not lit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      legal[i] = (code[i] == RED) || (code[i] == GREEN) || (code[i] == YELLOW);
      green[i] = (code[i] == GREEN);
      lit[i]   = legal[i] && (code[i] != RED);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        qcnt_q[i]  <= '0;
      end
      sensor_q   <= '0;
      ovf_q      <= '0;
      cerr_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        qcnt_q[i]  <= qcnt_d[i];
      end
      sensor_q   <= sensor_d;
      ovf_q      <= ovf_d;
      cerr_q     <= cerr_d;
      conflict_q <= conflict_d;
    end
  end

  // Next-state: lane FSMs, queue arithmetic and sticky flags
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      qcnt_d[i]  = qcnt_q[i];
      dep[i]     = (state_q[i] == MOVE) && (cnt_q[i] == 4'd0);

      if (arr[i] && !dep[i]) begin
        if (qcnt_q[i] == MAXQ) ovf_d[i] = 1'b1;
        else                   qcnt_d[i] = qcnt_q[i] + 1'b1;
      end else if (dep[i] && !arr[i]) begin
        qcnt_d[i] = qcnt_q[i] - 1'b1;
      end

      case (state_q[i])
        IDLE: begin
          if (green[i] && (qcnt_q[i] != '0)) begin
            if (START_DLY == 0) begin
              state_d[i] = MOVE;
              cnt_d[i]   = DEP_RELOAD;
            end else begin
              state_d[i] = WAIT;
              cnt_d[i]   = START_RELOAD;
            end
          end
        end
        WAIT: begin
          if (!green[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == 4'd0) begin
            state_d[i] = MOVE;
            cnt_d[i]   = DEP_RELOAD;
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end
        end
        MOVE: begin
          // A lamp change mid-departure never aborts the car already moving.
          if (cnt_q[i] == 4'd0) begin
            if (green[i] && (qcnt_d[i] != '0)) begin
              state_d[i] = MOVE;
              cnt_d[i]   = DEP_RELOAD;
            end else begin
              state_d[i] = IDLE;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      sensor_d[i] = (qcnt_d[i] != '0);
    end

    cerr_d     = cerr_q | ~legal;
    conflict_d = conflict_q
               | (lit[2] & (lit[0] | lit[1] | lit[3]))
               | (lit[3] & lit[1]);
  end

  // Outputs
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      moving[i] = (state_q[i] == MOVE);
    end
  end

  assign {W, EL, NL, E} = sensor_q;
  assign q_E      = qcnt_q[0];
  assign q_NL     = qcnt_q[1];
  assign q_EL     = qcnt_q[2];
  assign q_W      = qcnt_q[3];
  assign overflow = ovf_q;
  assign code_err = cerr_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_traffic_lane_model.sv
// Directed closed-loop bench for traffic_lane_model (QW=4, DEP_CYC=2, START_DLY=1).
// Expectations are queued before each edge and compared just after it.
module tb_traffic_lane_model;

  localparam logic [6:0] RED    = 7'b0101111;
  localparam logic [6:0] GREEN  = 7'b0010000;
  localparam logic [6:0] YELLOW = 7'b0010001;

  localparam int S_QE = 0, S_QNL = 1, S_QEL = 2, S_QW = 3, S_SENS = 4,
                 S_MOV = 5, S_OVF = 6, S_CERR = 7, S_CONF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       arr_E, arr_NL, arr_EL, arr_W;
  logic [6:0] ETL, NLTL, ELTL, WTL;
  logic       E, NL, EL, W;
  logic [3:0] q_E, q_NL, q_EL, q_W;
  logic [3:0] moving, overflow, code_err;
  logic       conflict;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  traffic_lane_model #(.QW(4), .DEP_CYC(2), .START_DLY(1)) dut (
    .clk(clk), .reset(reset),
    .arr_E(arr_E), .arr_NL(arr_NL), .arr_EL(arr_EL), .arr_W(arr_W),
    .ETL(ETL), .NLTL(NLTL), .ELTL(ELTL), .WTL(WTL),
    .E(E), .NL(NL), .EL(EL), .W(W),
    .q_E(q_E), .q_NL(q_NL), .q_EL(q_EL), .q_W(q_W),
    .moving(moving), .overflow(overflow), .code_err(code_err), .conflict(conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observed(int sel);
    case (sel)
      S_QE:    return 32'(q_E);
      S_QNL:   return 32'(q_NL);
      S_QEL:   return 32'(q_EL);
      S_QW:    return 32'(q_W);
      S_SENS:  return 32'({W, EL, NL, E});
      S_MOV:   return 32'(moving);
      S_OVF:   return 32'(overflow);
      S_CERR:  return 32'(code_err);
      default: return 32'(conflict);
    endcase
  endfunction

  task automatic expect_val(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(string tag);
    for (int s = 0; s <= S_CONF; s++) expect_val($sformatf("%s_sel%0d", tag, s), s, 32'd0);
  endtask

  task automatic tick_check();
    exp_t        e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observed(e.sel);
      n_cmp++;
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    int qe[8];
    int mv[8];
    qe = '{3, 3, 3, 2, 2, 1, 1, 0};
    mv = '{0, 1, 1, 1, 1, 1, 1, 0};

    reset = 1'b0;
    {arr_E, arr_NL, arr_EL, arr_W} = 4'b0;
    ETL = RED; NLTL = RED; ELTL = RED; WTL = RED;
    #2;

    // Reset held for two edges
    repeat (2) begin
      expect_all_zero("rst");
      tick_check();
    end

    // Test 1: three arrivals on E under Red
    reset = 1'b1;
    arr_E = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      expect_val("t1_qE", S_QE, 32'(k));
      expect_val("t1_sens", S_SENS, 32'd1);
      if (k == 3) begin
        expect_val("t1_mov", S_MOV, 32'd0);
        expect_val("t1_ovf", S_OVF, 32'd0);
        expect_val("t1_cerr", S_CERR, 32'd0);
        expect_val("t1_conf", S_CONF, 32'd0);
      end
      tick_check();
    end
    arr_E = 1'b0;

    // Test 2: E goes Green, one wait cycle then departures every 2 cycles
    ETL = GREEN;
    for (int k = 0; k < 8; k++) begin
      expect_val($sformatf("t2_qE_%0d", k), S_QE, 32'(qe[k]));
      expect_val($sformatf("t2_mov_%0d", k), S_MOV, 32'(mv[k]));
      expect_val($sformatf("t2_sens_%0d", k), S_SENS, (qe[k] != 0) ? 32'd1 : 32'd0);
      tick_check();
    end
    ETL = RED;

    // Test 3: W lane, Yellow arrives mid-departure
    arr_W = 1'b1;
    expect_val("t3_qW_a", S_QW, 32'd1); tick_check();
    expect_val("t3_qW_b", S_QW, 32'd2); tick_check();
    arr_W = 1'b0;
    WTL = GREEN;
    expect_val("t3_wait_q", S_QW, 32'd2); expect_val("t3_wait_mv", S_MOV, 32'd0); tick_check();
    expect_val("t3_mv1_q", S_QW, 32'd2);  expect_val("t3_mv1_mv", S_MOV, 32'h8); tick_check();
    WTL = YELLOW;
    expect_val("t3_mv2_q", S_QW, 32'd2);  expect_val("t3_mv2_mv", S_MOV, 32'h8); tick_check();
    expect_val("t3_dep_q", S_QW, 32'd1);  expect_val("t3_dep_mv", S_MOV, 32'd0); tick_check();
    expect_val("t3_hold_q", S_QW, 32'd1); expect_val("t3_hold_sens", S_SENS, 32'h8); tick_check();
    WTL = RED;
    expect_val("t3_red_q", S_QW, 32'd1);  expect_val("t3_red_mv", S_MOV, 32'd0); tick_check();

    // Test 4: NL saturation, then arrival coinciding with a departure
    arr_NL = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        expect_val("t4_full_q", S_QNL, 32'd15);
        expect_val("t4_full_ovf", S_OVF, 32'd0);
      end
      tick_check();
    end
    expect_val("t4_drop_q", S_QNL, 32'd15); expect_val("t4_drop_ovf", S_OVF, 32'h2); tick_check();
    arr_NL = 1'b0;
    NLTL = GREEN;
    expect_val("t4_wait_mv", S_MOV, 32'd0); tick_check();
    expect_val("t4_mv1", S_MOV, 32'h2);     tick_check();
    expect_val("t4_mv2", S_MOV, 32'h2);     tick_check();
    arr_NL = 1'b1;
    expect_val("t4_coinc_q", S_QNL, 32'd15); expect_val("t4_coinc_ovf", S_OVF, 32'h2);
    expect_val("t4_coinc_mv", S_MOV, 32'h2); tick_check();
    arr_NL = 1'b0;
    expect_val("t4_b2b_q", S_QNL, 32'd15); tick_check();
    expect_val("t4_dep2_q", S_QNL, 32'd14); expect_val("t4_dep2_mv", S_MOV, 32'h2); tick_check();
    NLTL = RED;
    expect_val("t4_fin_q", S_QNL, 32'd14); tick_check();
    expect_val("t4_last_q", S_QNL, 32'd13); expect_val("t4_last_mv", S_MOV, 32'd0);
    expect_val("t4_noconf", S_CONF, 32'd0); tick_check();

    // Test 5: EL Green with W Yellow is a conflict; bad E code flags and acts as Red
    ELTL = GREEN;
    WTL  = YELLOW;
    expect_val("t5_conf", S_CONF, 32'd1); tick_check();
    ELTL = RED;
    WTL  = RED;
    expect_val("t5_conf_sticky", S_CONF, 32'd1); expect_val("t5_cerr_clean", S_CERR, 32'd0); tick_check();
    ETL   = 7'b0000000;
    arr_E = 1'b1;
    expect_val("t5_cerr", S_CERR, 32'h1); expect_val("t5_qE", S_QE, 32'd1); tick_check();
    arr_E = 1'b0;
    repeat (2) begin
      expect_val("t5_asred_q", S_QE, 32'd1); expect_val("t5_asred_mv", S_MOV, 32'd0); tick_check();
    end
    ETL = RED;
    expect_val("t5_cerr_sticky", S_CERR, 32'h1); tick_check();

    // Test 6: reset while W is mid-departure with four cars queued
    arr_W = 1'b1;
    tick_check();
    tick_check();
    expect_val("t6_qW", S_QW, 32'd4); tick_check();
    arr_W = 1'b0;
    WTL = GREEN;
    expect_val("t6_wait_mv", S_MOV, 32'd0); tick_check();
    expect_val("t6_mv", S_MOV, 32'h8); expect_val("t6_mv_q", S_QW, 32'd4); tick_check();
    reset = 1'b0;
    expect_all_zero("t6_rst");
    tick_check();
    reset = 1'b1;
    WTL = RED;
    expect_all_zero("t6_post");
    tick_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_lane_model.md
Name: traffic_lane_model

Overview:
- Closed-loop vehicle/sensor model for the traffic controller: the consumer end of its lamp-code interface and the producer of its sensor inputs.
- Takes arrival pulses for four approaches (E, NL, EL, W) and keeps a per-lane queue count. Cars leave a lane only while that lane's 7-bit lamp code is Green.
- Drives the E/NL/EL/W sensor lines back to the controller.
- Flags malformed lamp codes and conflicting green/yellow combinations, so simulation benches can check the controller in a closed loop.

Parameters:
- QW, 4, queue counter width; saturation value MAXQ = 2^QW-1.
- DEP_CYC, 2, cycles a departing car occupies the stop line (range 1..15).
- START_DLY, 1, cycles from the Red/Yellow->Green edge until the first departure may begin (range 0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- arr_E, arr_NL, arr_EL, arr_W  in  1 each  arrival pulse; one car per cycle high.
- ETL, NLTL, ELTL, WTL  in  7 each  lamp codes: Red=7'b0101111, Green=7'b0010000, Yellow=7'b0010001.
- E, NL, EL, W  out  1 each  sensor; registered; high when that lane's queue > 0.
- q_E, q_NL, q_EL, q_W  out  QW each  queue counts.
- moving  out  4  per-lane departure in progress, bit order {W,EL,NL,E}.
- overflow  out  4  sticky; an arrival was dropped at MAXQ.
- code_err  out  4  sticky; the lane's lamp code was not one of the three legal codes.
- conflict  out  1  sticky; an illegal lamp combination was sampled.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, all lane FSMs IDLE, all delay counters 0. Reset applies mid-departure too: the car in progress is discarded and not counted.
- Each lane has an identical, independent FSM with states IDLE, WAIT, MOVE and a 4-bit counter cnt.
- Lamp-code decode: lit = (code != Red), with Green and Yellow both counting as lit. An illegal code is treated as Red for queue logic and sets code_err[lane].
- IDLE:
  - Green && q>0 && START_DLY==0 -> MOVE, cnt=DEP_CYC-1.
  - Green && q>0 && START_DLY>0 -> WAIT, cnt=START_DLY-1.
  - Otherwise stay in IDLE.
- WAIT:
  - Not Green -> IDLE.
  - cnt==0 -> MOVE, cnt=DEP_CYC-1.
  - Otherwise cnt--.
- MOVE:
  - cnt==0 -> the car departs (q decrements this edge).
  - After departing: if Green && q_next>0 -> MOVE again, reload cnt=DEP_CYC-1, with no start delay between back-to-back cars. Otherwise -> IDLE.
  - cnt!=0 -> cnt--.
  - The lamp going Yellow or Red during MOVE does not abort the car; it completes its departure.
- Start-delay rule: the delay applies only when leaving IDLE. A lane that returns to IDLE while still Green (queue emptied) and then gets a new arrival pays START_DLY again.
- Queue arithmetic, per edge: q_next = q + arr - dep.
  - arr and dep both active in one cycle: q unchanged, no overflow.
  - Arrival with q==MAXQ and no dep: q stays MAXQ and overflow[lane] is set.
  - q never underflows: dep requires MOVE, and MOVE is only entered with q>0.
- Sensor timing: sensor = (q_next != 0), registered. It therefore rises on the same edge that registers the first arrival.
- moving[lane] = (state==MOVE).
- Conflict check, sampled every cycle after reset. conflict is set if either holds:
  - lit(ELTL) && (lit(ETL) || lit(NLTL) || lit(WTL));
  - lit(WTL) && lit(NLTL).
- Flags overflow, code_err and conflict stay high until reset.

Test Plan:
1. Reset low 2 cycles, all lamps Red, arr_E pulsed 3 cycles -> q_E=3, E=1 after the 3rd edge; no departures; all flags 0.
2. ETL=Green after test 1, START_DLY=1, DEP_CYC=2 -> WAIT 1 cycle, then q_E goes 3->2->1->0 at 2-cycle spacing. E falls on the edge q_E hits 0; moving[0] held high for 6 cycles.
3. WTL=Green, q_W=2, lamp switches to Yellow mid-MOVE -> that car still completes (q_W=1), FSM goes IDLE, and the remaining car waits.
4. q_NL=15 (QW=4), arr_NL pulse with NLTL Red -> q_NL stays 15, overflow[1]=1. Next cycle: arr_NL coincident with a departure under Green -> q_NL stays 15, no further effect.
5. ELTL=Green and WTL=Yellow for one cycle -> conflict=1 and sticky. Separately, ETL=7'b0000000 -> code_err[0]=1 and the lane behaves as Red.
6. reset asserted while moving[3]=1, q_W=4 -> the next edge gives q_W=0, W=0, moving=0, and all flags cleared.
